mem_arb: RTL and testbench

- Shares one single-outstanding memory bus port between the instruction-fetch requester (IFU imem port) and the load/store requester (dmem port).
- Captures single-cycle requests, arbitrates with data priority plus an anti-starvation counter, and drives the bus.
- Returns each response to its owner using the busy/rdata/bad convention the IFU consumes.
- Sits between the CPU core and the L1/bus interconnect.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_slot.sv | 51 +++++
 rtl/mem_arb.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  // Fault field layout shared by m_err, imem_bad and dmem_bad.
  localparam int          BAD_XES  = 1;
  localparam int          BAD_PAGE = 0;
  localparam logic [1:0]  BAD_OK   = 2'b00;

  function automatic logic [1:0] bad_of(input logic [1:0] err);
    logic [1:0] bad;
    bad           = BAD_OK;
    bad[BAD_XES]  = err[BAD_XES];
    bad[BAD_PAGE] = err[BAD_PAGE];
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request register: captured on a request pulse, dropped on grant or kill.
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic                clear,
  input  logic                kill,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                valid,
  output logic [ADDR_W-1:0]   q_addr,
  output logic                q_we,
  output logic [DATA_W/8-1:0] q_wstrb,
  output logic [DATA_W-1:0]   q_wdata
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (capture) begin
      // A new request beats a same-cycle kill: the kill targets the old fetch.
      valid <= 1'b1;
    end else if (clear || kill) begin
      valid <= 1'b0;
    end
  end

  // NOTE: payload is reset too, so the bus never shows X fields after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr  <= '0;
      q_we    <= 1'b0;
      q_wstrb <= '0;
      q_wdata <= '0;
    end else if (capture) begin
      q_addr  <= addr;
      q_we    <= we;
      q_wstrb <= wstrb;
      q_wdata <= wdata;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-outstanding bus port between the fetch and load/store requesters,
// with data priority bounded by an anti-starvation streak counter.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_kill,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic [1:0]          imem_bad,
  output logic                imem_busy,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic [1:0]          dmem_bad,
  output logic                dmem_busy,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_err
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

  state_e                state;
  owner_e                owner;
  logic [STREAK_W-1:0]   streak;
  logic                  i_killed;
  logic                  inflight_we;

  logic                  i_pend, d_pend;
  logic [ADDR_W-1:0]     i_addr, d_addr;
  logic                  i_we, d_we;
  logic [STRB_W-1:0]     i_wstrb, d_wstrb;
  logic [DATA_W-1:0]     i_wdata, d_wdata;

  logic [DATA_W-1:0]     i_rdata_q, d_rdata_q;
  logic [1:0]            i_bad_q, d_bad_q;

  logic i_cap, d_cap;
  logic i_on_bus, i_kill_pend, i_pend_eff;
  logic granted, i_clear, d_clear;
  logic sel_i;
  logic resp_i, resp_d, i_killed_now;
  logic [1:0] resp_bad;

  assign i_cap = imem_req & ~imem_busy;
  assign d_cap = dmem_req & ~dmem_busy;

  // A fetch already driven on the bus cannot be withdrawn; any other pending fetch can.
  assign i_on_bus    = (state == ST_ISSUE) && (owner == OWN_I);
  assign i_kill_pend = imem_kill & ~i_on_bus;
  assign i_pend_eff  = i_pend & ~i_kill_pend;

  assign granted = (state == ST_ISSUE) & m_req & m_gnt;
  assign i_clear = granted & (owner == OWN_I);
  assign d_clear = granted & (owner == OWN_D);

  assign sel_i = i_pend_eff & (~d_pend | (streak == STREAK_SAT));

  assign resp_i       = (state == ST_WAIT) & m_rvalid & (owner == OWN_I);
  assign resp_d       = (state == ST_WAIT) & m_rvalid & (owner == OWN_D);
  assign i_killed_now = i_killed | imem_kill;
  assign resp_bad     = bad_of(m_err);

  assign imem_busy = i_pend | ((state == ST_WAIT) & (owner == OWN_I) & ~m_rvalid);
  assign dmem_busy = d_pend | ((state == ST_WAIT) & (owner == OWN_D) & ~m_rvalid);

  // Response data bypasses in its arrival cycle, then holds the registered copy.
  assign imem_rdata = (resp_i & ~i_killed_now) ? m_rdata  : i_rdata_q;
  assign imem_bad   = (resp_i & ~i_killed_now) ? resp_bad : i_bad_q;
  assign dmem_rdata = (resp_d & ~inflight_we)  ? m_rdata  : d_rdata_q;
  assign dmem_bad   = resp_d                   ? resp_bad : d_bad_q;

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (i_cap),
    .clear   (i_clear),
    .kill    (i_kill_pend),
    .addr    (imem_addr),
    .we      (1'b0),
    .wstrb   ('0),
    .wdata   ('0),
    .valid   (i_pend),
    .q_addr  (i_addr),
    .q_we    (i_we),
    .q_wstrb (i_wstrb),
    .q_wdata (i_wdata)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (d_cap),
    .clear   (d_clear),
    .kill    (1'b0),
    .addr    (dmem_addr),
    .we      (dmem_we),
    .wstrb   (dmem_wstrb),
    .wdata   (dmem_wdata),
    .valid   (d_pend),
    .q_addr  (d_addr),
    .q_we    (d_we),
    .q_wstrb (d_wstrb),
    .q_wdata (d_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      streak      <= '0;
      i_killed    <= 1'b0;
      inflight_we <= 1'b0;
      m_req       <= 1'b0;
      m_addr      <= '0;
      m_we        <= 1'b0;
      m_wstrb     <= '0;
      m_wdata     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_pend_eff || d_pend) begin
            state       <= ST_ISSUE;
            owner       <= sel_i ? OWN_I : OWN_D;
            inflight_we <= sel_i ? i_we : d_we;
            m_req       <= 1'b1;
            m_addr      <= sel_i ? i_addr  : d_addr;
            m_we        <= sel_i ? i_we    : d_we;
            m_wstrb     <= sel_i ? i_wstrb : d_wstrb;
            m_wdata     <= sel_i ? i_wdata : d_wdata;
            // Streak counts D grants that bypassed a waiting fetch.
            if (sel_i || !i_pend_eff) begin
              streak <= '0;
            end else if (streak != STREAK_SAT) begin
              streak <= streak + STREAK_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (imem_kill && owner == OWN_I) begin
            i_killed <= 1'b1;
          end
          if (m_gnt) begin
            state   <= ST_WAIT;
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_we    <= 1'b0;
            m_wstrb <= '0;
            m_wdata <= '0;
          end
        end
        ST_WAIT: begin
          if (m_rvalid) begin
            state    <= ST_IDLE;
            i_killed <= 1'b0;
          end else if (imem_kill && owner == OWN_I) begin
            i_killed <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      i_bad_q   <= BAD_OK;
      d_rdata_q <= '0;
      d_bad_q   <= BAD_OK;
    end else begin
      if (resp_i && !i_killed_now) begin
        i_rdata_q <= m_rdata;
        i_bad_q   <= resp_bad;
      end
      // Writes report status only; load data from an earlier read stays visible.
      if (resp_d) begin
        if (!inflight_we) begin
          d_rdata_q <= m_rdata;
        end
        d_bad_q <= resp_bad;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: stimulus pushes expected bus beats and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_kill;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_bad;
  logic        imem_busy;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  dmem_bad;
  logic        dmem_busy;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_err;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
  } rsp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  bad;
    int          busy_len;
  } exp_t;

  beat_t bus_q[$];
  rsp_t  rsp_q[$];
  exp_t  i_q[$];
  exp_t  d_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic gnt_en;
  int   rv_delay;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_kill  (imem_kill),
    .imem_rdata (imem_rdata),
    .imem_bad   (imem_bad),
    .imem_busy  (imem_busy),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_wstrb (dmem_wstrb),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_bad   (dmem_bad),
    .dmem_busy  (dmem_busy),
    .m_req      (m_req),
    .m_addr     (m_addr),
    .m_we       (m_we),
    .m_wstrb    (m_wstrb),
    .m_wdata    (m_wdata),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .m_err      (m_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Bus responder: grants when enabled, answers rv_delay cycles after the grant.
  initial begin
    int   rv_cnt;
    rsp_t cur;
    rv_cnt   = 0;
    cur      = '{data: 32'h0, err: 2'b00};
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_err    = '0;
    forever begin
      @(posedge clk);
      #1;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      if (rst) begin
        rv_cnt = 0;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = cur.data;
          m_err    = cur.err;
        end
      end else if (m_req && gnt_en) begin
        m_gnt = 1'b1;
        if (rsp_q.size() != 0) cur = rsp_q.pop_front();
        rv_cnt = rv_delay;
      end
    end
  end

  // Monitor: bus beats, response-cycle values, busy lengths and held values.
  logic [31:0] i_hold_rdata, d_hold_rdata;
  logic [1:0]  i_hold_bad, d_hold_bad;
  logic        i_prev, d_prev;
  int          i_len, d_len;
  beat_t       mb;
  exp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      i_prev = 1'b0; d_prev = 1'b0;
      i_len  = 0;    d_len  = 0;
      i_hold_rdata = '0; i_hold_bad = '0;
      d_hold_rdata = '0; d_hold_bad = '0;
    end else begin
      if (m_req && m_gnt) begin
        check("bus_beat_expected", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          mb = bus_q.pop_front();
          check("bus_addr",  m_addr,  mb.addr);
          check("bus_we",    m_we,    mb.we);
          check("bus_wstrb", m_wstrb, mb.wstrb);
          check("bus_wdata", m_wdata, mb.wdata);
        end
      end

      if (imem_busy) begin
        i_len++;
      end else if (i_prev) begin
        check("i_resp_expected", i_q.size() != 0, 1);
        if (i_q.size() != 0) begin
          me = i_q.pop_front();
          check("imem_rdata", imem_rdata, me.rdata);
          check("imem_bad",   imem_bad,   me.bad);
          if (me.busy_len != 0) check("imem_busy_len", i_len, me.busy_len);
          i_hold_rdata = me.rdata;
          i_hold_bad   = me.bad;
        end
        i_len = 0;
      end else begin
        check("imem_rdata_hold", imem_rdata, i_hold_rdata);
        check("imem_bad_hold",   imem_bad,   i_hold_bad);
      end
      i_prev = imem_busy;

      if (dmem_busy) begin
        d_len++;
      end else if (d_prev) begin
        check("d_resp_expected", d_q.size() != 0, 1);
        if (d_q.size() != 0) begin
          me = d_q.pop_front();
          check("dmem_rdata", dmem_rdata, me.rdata);
          check("dmem_bad",   dmem_bad,   me.bad);
          if (me.busy_len != 0) check("dmem_busy_len", d_len, me.busy_len);
          d_hold_rdata = me.rdata;
          d_hold_bad   = me.bad;
        end
        d_len = 0;
      end else begin
        check("dmem_rdata_hold", dmem_rdata, d_hold_rdata);
        check("dmem_bad_hold",   dmem_bad,   d_hold_bad);
      end
      d_prev = dmem_busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((imem_busy || dmem_busy || m_req) && n < 300) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < 300, 1);
    tick();
    tick();
  endtask

  task automatic wait_d_free();
    int n = 0;
    while (dmem_busy && n < 100) begin
      tick();
      n++;
    end
    check("dmem_free_within_budget", n < 100, 1);
  endtask

  task automatic fetch(input logic [31:0] addr);
    imem_req  = 1'b1;
    imem_addr = addr;
    tick();
    imem_req  = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    dmem_req   = 1'b1;
    dmem_we    = we;
    dmem_wstrb = strb;
    dmem_addr  = addr;
    dmem_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1;
    imem_req = 1'b0; imem_kill = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_wstrb = '0; dmem_addr = '0; dmem_wdata = '0;
    gnt_en   = 1'b1;
    rv_delay = 2;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_m_req",      m_req,      0);
    check("rst_m_addr",     m_addr,     0);
    check("rst_imem_busy",  imem_busy,  0);
    check("rst_dmem_busy",  dmem_busy,  0);
    check("rst_imem_rdata", imem_rdata, 0);
    check("rst_dmem_rdata", dmem_rdata, 0);
    check("rst_imem_bad",   imem_bad,   0);

    // Single fetch: busy for IDLE, ISSUE and WAIT, falls with the response.
    bus_q.push_back('{addr: 32'h100, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0013, err: 2'b00});
    i_q.push_back('{rdata: 32'h0000_0013, bad: 2'b00, busy_len: 3});
    fetch(32'h100);
    wait_idle();

    // Starvation: four D grants pass a waiting fetch, then the fetch wins.
    for (int k = 0; k < 4; k++) begin
      bus_q.push_back('{addr: 32'h400 + 32'(4*k), we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
      rsp_q.push_back('{data: 32'h1000 + 32'(k), err: 2'b00});
      d_q.push_back('{rdata: 32'h1000 + 32'(k), bad: 2'b00, busy_len: 3});
    end
    bus_q.push_back('{addr: 32'h180, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0513, err: 2'b00});
    i_q.push_back('{rdata: 32'h0000_0513, bad: 2'b00, busy_len: 19});
    bus_q.push_back('{addr: 32'h410, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h1004, err: 2'b00});
    d_q.push_back('{rdata: 32'h1004, bad: 2'b00, busy_len: 7});

    imem_req  = 1'b1;
    imem_addr = 32'h180;
    data_req(1'b0, 4'h0, 32'h400, 32'h0);
    tick();
    imem_req = 1'b0;
    dmem_req = 1'b0;
    for (int k = 1; k < 5; k++) begin
      wait_d_free();
      data_req(1'b0, 4'h0, 32'h400 + 32'(4*k), 32'h0);
      tick();
      dmem_req = 1'b0;
    end
    wait_idle();

    // Contention: simultaneous capture, D write goes first; write keeps old load data.
    bus_q.push_back('{addr: 32'h200, we: 1'b1, wstrb: 4'hF, wdata: 32'hCAFE_F00D});
    rsp_q.push_back('{data: 32'hBAD0_BAD0, err: 2'b00});
    d_q.push_back('{rdata: 32'h1004, bad: 2'b00, busy_len: 3});
    bus_q.push_back('{addr: 32'h300, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0093, err: 2'b00});
    i_q.push_back('{rdata: 32'h0000_0093, bad: 2'b00, busy_len: 7});
    imem_req  = 1'b1;
    imem_addr = 32'h300;
    data_req(1'b1, 4'hF, 32'h200, 32'hCAFE_F00D);
    tick();
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wait_idle();

    // Kill in WAIT: 0xDEAD is discarded, busy still spans to the response.
    rv_delay = 4;
    bus_q.push_back('{addr: 32'h500, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_DEAD, err: 2'b11});
    i_q.push_back('{rdata: 32'h0000_0093, bad: 2'b00, busy_len: 5});
    fetch(32'h500);
    begin
      int n = 0;
      while (!(m_req && m_gnt) && n < 50) begin
        tick();
        n++;
      end
      check("kill_grant_within_budget", n < 50, 1);
    end
    tick();
    imem_kill = 1'b1;
    tick();
    imem_kill = 1'b0;
    wait_idle();
    rv_delay = 2;

    bus_q.push_back('{addr: 32'h504, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0011, err: 2'b00});
    i_q.push_back('{rdata: 32'h0000_0011, bad: 2'b00, busy_len: 3});
    fetch(32'h504);
    wait_idle();

    // Kill before selection: no bus beat, busy for one cycle only.
    gnt_en = 1'b0;
    i_q.push_back('{rdata: 32'h0000_0011, bad: 2'b00, busy_len: 1});
    fetch(32'h600);
    imem_kill = 1'b1;
    tick();
    imem_kill = 1'b0;
    repeat (3) tick();
    gnt_en = 1'b1;
    wait_idle();

    // Error response on a load: dmem_bad reports it and holds, imem_bad untouched.
    bus_q.push_back('{addr: 32'h640, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0077, err: 2'b10});
    d_q.push_back('{rdata: 32'h0000_0077, bad: 2'b10, busy_len: 3});
    data_req(1'b0, 4'h0, 32'h640, 32'h0);
    tick();
    dmem_req = 1'b0;
    wait_idle();

    // Reset while ISSUE waits for a grant that never comes.
    gnt_en = 1'b0;
    fetch(32'h700);
    tick();
    check("issue_m_req",  m_req,  1);
    check("issue_m_addr", m_addr, 32'h700);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_m_req",      m_req,      0);
    check("post_rst_imem_busy",  imem_busy,  0);
    check("post_rst_imem_rdata", imem_rdata, 0);
    check("post_rst_dmem_bad",   dmem_bad,   0);
    gnt_en = 1'b1;
    tick();

    bus_q.push_back('{addr: 32'h704, we: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{data: 32'h0000_0055, err: 2'b00});
    i_q.push_back('{rdata: 32'h0000_0055, bad: 2'b00, busy_len: 3});
    fetch(32'h704);
    wait_idle();

    check("bus_q_drained", bus_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("i_q_drained",   i_q.size(),   0);
    check("d_q_drained",   d_q.size(),   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
